// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU access at a time, drives a single-cycle SRAM
// port, and returns a one-cycle response with aligned, extended load data.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ACCESS    = 2'd1,
        S_READ_DATA = 2'd2,
        S_RESP      = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [1:0]            r_addr_lo;
    logic                  r_resp_valid;
    logic [31:0]           r_resp_rdata;
    logic                  r_resp_err;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [3:0]            r_mem_be;
    logic                  r_mem_we;
    logic [31:0]           r_mem_wdata;

    logic                  w_illegal;
    logic                  w_misaligned;
    logic [3:0]            w_store_be;
    logic [31:0]           w_store_wdata;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load_data;
    logic                  w_unused;

    // Address bits above the SRAM word range are intentionally ignored.
    assign w_unused = ^{req_addr[31:ADDR_WIDTH+2]};

    // Request classification: illegal size code or misaligned address.
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        if (req_we) begin
            w_illegal = (req_funct3 > 3'b010);
        end else begin
            w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        case (req_funct3[1:0])
            2'b01:   w_misaligned = req_addr[0];
            2'b10:   w_misaligned = |req_addr[1:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    // Store lane steering: data replicated across lanes, enables pick the target.
    always_comb begin
        w_store_be    = 4'b0000;
        w_store_wdata = 32'd0;
        case (req_funct3[1:0])
            2'b00: begin
                w_store_be    = 4'(4'b0001 << req_addr[1:0]);
                w_store_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_store_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_store_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_store_be    = 4'b1111;
                w_store_wdata = req_wdata;
            end
        endcase
    end

    // Load data selection and extension from the returned SRAM word.
    always_comb begin
        w_byte      = mem_rdata[{r_addr_lo, 3'b000} +: 8];
        w_half      = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_load_data = mem_rdata;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= 4'b0000;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_funct3    <= req_funct3;
                        r_addr_lo   <= req_addr[1:0];
                        r_req_ready <= 1'b0;
                        if (w_illegal || w_misaligned) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'd0;
                        end else begin
                            r_state    <= S_ACCESS;
                            r_mem_addr <= req_addr[ADDR_WIDTH+1:2];
                            r_mem_we   <= req_we;
                            if (req_we) begin
                                r_mem_be    <= w_store_be;
                                r_mem_wdata <= w_store_wdata;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    r_mem_we <= 1'b0;
                    r_mem_be <= 4'b0000;
                    if (r_we) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= 32'd0;
                    end else begin
                        r_state <= S_READ_DATA;
                    end
                end
                S_READ_DATA: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= w_load_data;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_addr   = r_mem_addr;
    assign mem_be     = r_mem_be;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: SRAM model, transaction-level reference model with a
// per-cycle compare process, and directed vectors with literal expectations.
module tb_load_store_unit;

    localparam int unsigned AW = 12;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int n_checks = 0;
    int n_errs   = 0;

    load_store_unit #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // SRAM: byte-enabled write, registered read one cycle after address sample.
    bit [31:0] sram [4096];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_we && mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= sram[mem_addr];
    end

    // ---------------- reference model ----------------
    bit [31:0] gmem [4096];

    function automatic int unsigned f_size(input logic [2:0] f3);
        return 32'd1 << f3[1:0];
    endfunction

    function automatic logic f_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic legal;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !legal || ((a % f_size(f3)) != 0);
    endfunction

    function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] be;
        int unsigned off;
        be  = 4'b0000;
        off = a % 4;
        for (int b = 0; b < 4; b++)
            if (b >= off && b < off + f_size(f3)) be[b] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] f_wd(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        r = 32'd0;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = wd[8*(b % f_size(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int unsigned sz;
        longint      v;
        longint      range;
        sz    = f_size(f3);
        range = 64'sd1 << (8 * sz);
        v     = longint'((64'(w) >> (8 * ((a % 4) / sz * sz))) % range);
        if (!f3[2] && sz < 4 && v >= range / 2) v = v - range;
        return 32'(v);
    endfunction

    int          m_k     = 0;
    int          m_lat   = 0;
    logic        m_err   = 1'b0;
    logic        m_store = 1'b0;
    logic [AW-1:0] m_idx = '0;
    logic [3:0]  m_be    = 4'b0000;
    logic [31:0] m_wd    = 32'd0;
    logic [31:0] m_rd    = 32'd0;
    logic [31:0] m_rdata = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k     <= 0;
            m_rdata <= 32'd0;
        end else if (m_k == 0) begin
            if (req_valid) begin
                m_k     <= 1;
                m_err   <= f_err(req_we, req_funct3, req_addr);
                m_store <= req_we;
                m_idx   <= AW'(req_addr >> 2);
                m_be    <= f_be(req_funct3, req_addr);
                m_wd    <= f_wd(req_funct3, req_wdata);
                if (f_err(req_we, req_funct3, req_addr)) begin
                    m_lat   <= 1;
                    m_rdata <= 32'd0;
                end else if (req_we) begin
                    m_lat <= 2;
                    m_rd  <= 32'd0;
                end else begin
                    m_lat <= 3;
                    m_rd  <= f_load(req_funct3, req_addr, gmem[AW'(req_addr >> 2)]);
                end
            end
        end else if (m_k == m_lat) begin
            m_k <= 0;
        end else begin
            if (m_k == 1 && m_store)
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) gmem[m_idx][8*b +: 8] <= m_wd[8*b +: 8];
            if (m_k + 1 == m_lat) m_rdata <= m_rd;
            m_k <= m_k + 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic rv;
        logic acc;
        rv  = (m_k != 0) && (m_k == m_lat);
        acc = (m_k == 1) && !m_err;
        chk("req_ready", 32'(req_ready), 32'(m_k == 0));
        chk("resp_valid", 32'(resp_valid), 32'(rv));
        if (rv) chk("resp_err", 32'(resp_err), 32'(m_err));
        chk("resp_rdata", resp_rdata, m_rdata);
        chk("mem_we", 32'(mem_we), 32'(acc && m_store));
        chk("mem_be", 32'(mem_be), (acc && m_store) ? 32'(m_be) : 32'd0);
        if (acc) chk("mem_addr", 32'(mem_addr), 32'(m_idx));
        if (acc && m_store) chk("mem_wdata", mem_wdata, m_wd);
    end

    // ---------------- directed stimulus ----------------
    logic [AW-1:0] acc_addr;
    logic [3:0]    acc_be;
    logic          acc_we;
    logic [31:0]   acc_wdata;

    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int exp_lat, input logic exp_err,
                       input logic [31:0] exp_rd, input string nm);
        int   n;
        logic saw_we;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acc_addr  = mem_addr;
        acc_be    = mem_be;
        acc_we    = mem_we;
        acc_wdata = mem_wdata;
        saw_we    = mem_we;
        n = 1;
        while (!resp_valid && n < 8) begin
            @(posedge clk);
            #1;
            saw_we = saw_we | mem_we;
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
        chk({nm, "_err"}, 32'(resp_err), 32'(exp_err));
        chk({nm, "_rdata"}, resp_rdata, exp_rd);
        if (exp_err) chk({nm, "_no_we"}, 32'(saw_we), 32'd0);
        @(posedge clk);
    endtask

    initial begin
        int rv_cnt;
        int rdy_cnt;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        #7;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        #5 rst = 1'b0;

        txn(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 2, 1'b0, 32'd0, "sw");
        chk("sw_acc_addr", 32'(acc_addr), 32'h041);
        chk("sw_acc_be", 32'(acc_be), 32'hF);
        chk("sw_acc_we", 32'(acc_we), 32'd1);

        txn(1'b1, 3'b000, 32'h0000_0006, 32'h0000_00A5, 2, 1'b0, 32'd0, "sb");
        chk("sb_acc_be", 32'(acc_be), 32'b0100);
        chk("sb_acc_wdata", acc_wdata, 32'hA5A5_A5A5);

        txn(1'b1, 3'b010, 32'h0000_0010, 32'h80FF_7F01, 2, 1'b0, 32'd0, "sw_pre");
        txn(1'b0, 3'b000, 32'h0000_0011, 32'd0, 3, 1'b0, 32'h0000_007F, "lb11");
        txn(1'b0, 3'b000, 32'h0000_0012, 32'd0, 3, 1'b0, 32'hFFFF_FFFF, "lb12");
        txn(1'b0, 3'b100, 32'h0000_0012, 32'd0, 3, 1'b0, 32'h0000_00FF, "lbu12");
        txn(1'b0, 3'b001, 32'h0000_0012, 32'd0, 3, 1'b0, 32'hFFFF_80FF, "lh12");
        txn(1'b0, 3'b101, 32'h0000_0010, 32'd0, 3, 1'b0, 32'h0000_7F01, "lhu10");
        txn(1'b0, 3'b010, 32'h0000_0010, 32'd0, 3, 1'b0, 32'h80FF_7F01, "lw10");
        txn(1'b0, 3'b010, 32'h0000_0004, 32'd0, 3, 1'b0, 32'h00A5_0000, "lw04");
        txn(1'b0, 3'b010, 32'h0000_0104, 32'd0, 3, 1'b0, 32'hDEAD_BEEF, "lw104");

        txn(1'b1, 3'b001, 32'h0000_0022, 32'h0000_1234, 2, 1'b0, 32'd0, "sh22");
        chk("sh_acc_be", 32'(acc_be), 32'b1100);
        chk("sh_acc_wdata", acc_wdata, 32'h1234_1234);
        txn(1'b0, 3'b010, 32'h0000_0020, 32'd0, 3, 1'b0, 32'h1234_0000, "lw20");

        txn(1'b0, 3'b010, 32'h0000_0002, 32'd0, 1, 1'b1, 32'd0, "lw_mis");
        txn(1'b1, 3'b001, 32'h0000_0001, 32'h0000_FFFF, 1, 1'b1, 32'd0, "sh_mis");
        txn(1'b0, 3'b111, 32'h0000_0000, 32'd0, 1, 1'b1, 32'd0, "ld_ill");
        txn(1'b1, 3'b100, 32'h0000_0000, 32'd0, 1, 1'b1, 32'd0, "st_ill");

        // Reset pulse in the middle of a store access.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0030;
        req_wdata  = 32'h1122_3344;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort_pre_we", 32'(mem_we), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort_we", 32'(mem_we), 32'd0);
        chk("abort_be", 32'(mem_be), 32'd0);
        chk("abort_valid", 32'(resp_valid), 32'd0);
        #1 rst = 1'b0;
        txn(1'b0, 3'b010, 32'h0000_0030, 32'd0, 3, 1'b0, 32'd0, "lw30");

        // req_valid held high: one accept per completion.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b101;
        req_addr   = 32'h0000_0010;
        rv_cnt     = 0;
        rdy_cnt    = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp_valid) rv_cnt++;
            if (req_ready) rdy_cnt++;
        end
        req_valid = 1'b0;
        chk("b2b_resp_count", 32'(rv_cnt), 32'd3);
        chk("b2b_ready_count", 32'(rdy_cnt), 32'd3);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errs);
        $fatal(1);
    end

endmodule
